// File: rtl/debugger_output.sv
// debugger_output: streams a request-supplied byte buffer to the UART transmitter,
// expanding LF to CR LF and optionally appending a CR LF terminator.
module debugger_output #(
    parameter int COUNT = 64,
    localparam int LW = $clog2(COUNT + 1) + 1
) (
    input  logic               CLK,
    input  logic               RESET_n,
    input  logic               REQ_n,
    input  logic [8*COUNT-1:0] DATA,
    input  logic [LW-1:0]      LENGTH,
    input  logic               NEWLINE,
    output logic               ACK_n,
    output logic               BUSY,
    output logic [7:0]         TX_DATA,
    output logic               TX_WRITE,
    input  logic               TX_BUSY
);
    localparam int IW = COUNT > 1 ? $clog2(COUNT) : 1;
    localparam logic [LW-1:0] COUNT_W = LW'(COUNT);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, HOLD, CRLF_CR, CRLF_LF, COMPLETE} state_t;

    state_t        state_q, state_d, ret_q, ret_d;
    logic [LW-1:0] idx_q, idx_d, len_q, len_d;
    logic          nl_q, nl_d, lf_pend_q, lf_pend_d, hold_first_q, hold_first_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_write_q, tx_write_d;
    logic [7:0]    buf_bytes [COUNT];
    logic [7:0]    cur_byte;

    // Byte i of the buffer occupies DATA[8*i +: 8].
    for (genvar i = 0; i < COUNT; i++) begin : g_bytes
        assign buf_bytes[i] = DATA[8*i +: 8];
    end

    assign cur_byte = buf_bytes[idx_q[IW-1:0]];

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q      <= IDLE;
            ret_q        <= FETCH;
            idx_q        <= '0;
            len_q        <= '0;
            nl_q         <= 1'b0;
            lf_pend_q    <= 1'b0;
            hold_first_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            nl_q         <= nl_d;
            lf_pend_q    <= lf_pend_d;
            hold_first_q <= hold_first_d;
            tx_data_q    <= tx_data_d;
            tx_write_q   <= tx_write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        idx_d        = idx_q;
        len_d        = len_q;
        nl_d         = nl_q;
        lf_pend_d    = lf_pend_q;
        hold_first_d = 1'b0;
        tx_data_d    = tx_data_q;
        tx_write_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!REQ_n) begin
                    len_d     = LENGTH > COUNT_W ? COUNT_W : LENGTH;
                    nl_d      = NEWLINE;
                    idx_d     = '0;
                    lf_pend_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (REQ_n) begin
                    state_d = IDLE;
                end else if (idx_q == len_q) begin
                    state_d = nl_q ? CRLF_CR : COMPLETE;
                end else begin
                    state_d = ISSUE;
                    ret_d   = FETCH;
                    // An LF is visited twice: first pass sends CR, second pass sends the LF itself.
                    if (cur_byte == 8'h0A && !lf_pend_q) begin
                        lf_pend_d = 1'b1;
                        tx_data_d = 8'h0D;
                    end else begin
                        lf_pend_d = 1'b0;
                        tx_data_d = cur_byte;
                        idx_d     = idx_q + LW'(1);
                    end
                end
            end
            ISSUE: begin
                if (REQ_n) begin
                    state_d = IDLE;
                end else if (!TX_BUSY) begin
                    tx_write_d   = 1'b1;
                    hold_first_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                // TX_BUSY may lag the strobe by a cycle, so the first cycle is not trusted.
                if (!hold_first_q && !TX_BUSY) state_d = REQ_n ? IDLE : ret_q;
            end
            CRLF_CR: begin
                state_d   = REQ_n ? IDLE : ISSUE;
                tx_data_d = 8'h0D;
                ret_d     = CRLF_LF;
            end
            CRLF_LF: begin
                state_d   = REQ_n ? IDLE : ISSUE;
                tx_data_d = 8'h0A;
                ret_d     = COMPLETE;
            end
            COMPLETE: begin
                if (REQ_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ACK_n    = state_q != COMPLETE;
        BUSY     = state_q != IDLE;
        TX_DATA  = tx_data_q;
        TX_WRITE = tx_write_q;
    end
endmodule

// File: tb/tb_debugger_output.sv
// tb_debugger_output: directed table vectors plus hand-written reset, latency
// and abort sequences against a TX_BUSY responder model.
module tb_debugger_output;
    localparam int COUNT = 8;
    localparam int LW = $clog2(COUNT + 1) + 1;

    logic               CLK = 1'b0;
    logic               RESET_n = 1'b0;
    logic               REQ_n = 1'b1;
    logic [8*COUNT-1:0] DATA = '0;
    logic [LW-1:0]      LENGTH = '0;
    logic               NEWLINE = 1'b0;
    logic               ACK_n, BUSY, TX_WRITE;
    logic [7:0]         TX_DATA;
    logic               TX_BUSY = 1'b0;

    int checks = 0;
    int errors = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    logic prev_wr = 1'b0;
    logic [7:0] got [$];

    debugger_output #(.COUNT(COUNT)) dut (
        .CLK(CLK), .RESET_n(RESET_n), .REQ_n(REQ_n), .DATA(DATA), .LENGTH(LENGTH),
        .NEWLINE(NEWLINE), .ACK_n(ACK_n), .BUSY(BUSY), .TX_DATA(TX_DATA),
        .TX_WRITE(TX_WRITE), .TX_BUSY(TX_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for busy_len cycles after each accepted strobe.
    always @(posedge CLK) begin
        if (TX_WRITE && busy_len > 0) begin
            TX_BUSY  <= 1'b1;
            busy_cnt <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            TX_BUSY  <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (TX_WRITE) begin
            got.push_back(TX_DATA);
            chk("strobe_while_busy", {31'd0, TX_BUSY}, 32'd0);
            chk("strobe_width", {31'd0, prev_wr}, 32'd0);
        end
        prev_wr = TX_WRITE;
    end

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge CLK);
            if (!ACK_n) ok = 1'b1;
        end
    endtask

    task automatic xfer(input int len, input bit nl, input int busy);
        bit ok;
        got.delete();
        busy_len = busy;
        LENGTH = LW'(len);
        NEWLINE = nl;
        REQ_n = 1'b0;
        wait_ack(ok);
        chk("ack_timeout", {31'd0, ok}, 32'd1);
        REQ_n = 1'b1;
        @(negedge CLK);
        chk("ack_release", {31'd0, ACK_n}, 32'd1);
        chk("busy_release", {31'd0, BUSY}, 32'd0);
    endtask

    typedef struct {
        logic [63:0] d;
        int          len;
        bit          nl;
        int          busy;
        int          n;
        logic [79:0] e;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit ok;
        bit ack_seen;
        // byte k of d/e sits at bits [8k +: 8]
        vecs[0] = '{64'h4B4F, 2, 1'b1, 0, 4, 80'h0A0D4B4F};
        vecs[1] = '{64'h420A41, 3, 1'b0, 0, 4, 80'h420A0D41};
        vecs[2] = '{64'h420A41, 3, 1'b0, 10, 4, 80'h420A0D41};
        vecs[3] = '{64'h4B4F, 0, 1'b0, 0, 0, 80'h0};
        vecs[4] = '{64'h3736353433323130, COUNT + 5, 1'b0, 0, 8, 80'h3736353433323130};
        vecs[5] = '{64'h0A0D, 2, 1'b1, 0, 5, 80'h0A0D0A0D0D};
        vecs[6] = '{64'h0A0A, 2, 1'b0, 3, 4, 80'h0A0D0A0D};
        vecs[7] = '{64'h0, 0, 1'b1, 0, 2, 80'h0A0D};

        // Reset held with a pending request, then acceptance and first-strobe latency.
        REQ_n = 1'b0;
        DATA = 64'h4B4F;
        LENGTH = LW'(2);
        NEWLINE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("rst_ack", {31'd0, ACK_n}, 32'd1);
            chk("rst_busy", {31'd0, BUSY}, 32'd0);
            chk("rst_write", {31'd0, TX_WRITE}, 32'd0);
        end
        RESET_n = 1'b1;
        @(negedge CLK);
        chk("accept_busy", {31'd0, BUSY}, 32'd1);
        chk("lat_e0", {31'd0, TX_WRITE}, 32'd0);
        @(negedge CLK);
        chk("lat_e1", {31'd0, TX_WRITE}, 32'd0);
        @(negedge CLK);
        chk("lat_e2", {31'd0, TX_WRITE}, 32'd1);
        chk("lat_byte", {24'd0, TX_DATA}, 32'h4F);
        wait_ack(ok);
        chk("first_ack", {31'd0, ok}, 32'd1);
        REQ_n = 1'b1;
        @(negedge CLK);
        chk("first_ack_release", {31'd0, ACK_n}, 32'd1);

        // Zero-length request acknowledges within two cycles of accept.
        DATA = 64'h4B4F;
        LENGTH = '0;
        NEWLINE = 1'b0;
        got.delete();
        REQ_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        chk("len0_ack", {31'd0, ACK_n}, 32'd0);
        REQ_n = 1'b1;
        @(negedge CLK);
        chk("len0_strobes", got.size(), 0);

        for (int v = 0; v < 8; v++) begin
            DATA = vecs[v].d;
            xfer(vecs[v].len, vecs[v].nl, vecs[v].busy);
            chk($sformatf("v%0d_count", v), got.size(), vecs[v].n);
            for (int k = 0; k < vecs[v].n && k < got.size(); k++)
                chk($sformatf("v%0d_byte%0d", v, k), {24'd0, got[k]}, {24'd0, vecs[v].e[8*k +: 8]});
        end

        // Abort after the third strobe.
        DATA = 64'h3837363534333231;
        busy_len = 0;
        got.delete();
        LENGTH = LW'(8);
        NEWLINE = 1'b0;
        REQ_n = 1'b0;
        for (int i = 0; i < 200 && got.size() < 3; i++) begin
            @(negedge CLK);
            #1;
        end
        chk("abort_reached3", got.size(), 3);
        REQ_n = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!ACK_n) ack_seen = 1'b1;
        end
        chk("abort_strobes", got.size(), 3);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_no_ack", {31'd0, ack_seen}, 32'd0);
        xfer(2, 1'b0, 0);
        chk("restart_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("restart_b0", {24'd0, got[0]}, 32'h31);
            chk("restart_b1", {24'd0, got[1]}, 32'h32);
        end

        // Reset asserted while holding after the second strobe.
        got.delete();
        LENGTH = LW'(8);
        REQ_n = 1'b0;
        for (int i = 0; i < 200 && got.size() < 2; i++) begin
            @(negedge CLK);
            #1;
        end
        chk("rst_mid_reached2", got.size(), 2);
        RESET_n = 1'b0;
        REQ_n = 1'b1;
        @(negedge CLK);
        chk("rst_mid_write", {31'd0, TX_WRITE}, 32'd0);
        chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_mid_ack", {31'd0, ACK_n}, 32'd1);
        @(negedge CLK);
        RESET_n = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge CLK);
        chk("rst_mid_strobes", got.size(), 2);
        xfer(3, 1'b0, 0);
        chk("rst_restart_count", got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk($sformatf("rst_restart_b%0d", k), {24'd0, got[k]}, 32'h31 + k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debugger_output.md
Name: debugger_output

Overview:
UART output engine for the debugger, the transmit-side counterpart of the debugger line-input block. On a REQ_n/ACK_n request it streams a caller-supplied byte buffer to the UART transmitter one byte at a time. It expands LF (8'h0A) to CR LF and can optionally append a CR LF line terminator. It sits between the debugger command/monitor logic and the UART TX core.

Parameters:
COUNT, 64, buffer depth in bytes; LENGTH width is $clog2(COUNT+1)+1

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_n  input  1  reset; synchronous, active-low (sampled on CLK rising edge)
REQ_n  input  1  request, active-low; requester holds it low until ACK_n low
DATA  input  8 x COUNT  byte buffer DATA[0:COUNT-1]; stable while REQ_n low
LENGTH  input  $clog2(COUNT+1)+1  number of bytes to send; sampled at request accept
NEWLINE  input  1  1 = append CR LF after the buffer; sampled at request accept
ACK_n  output  1  completion acknowledge, active-low
BUSY  output  1  high from request accept until return to IDLE
TX_DATA  output  8  byte to the UART transmitter
TX_WRITE  output  1  single-cycle write strobe to the transmitter
TX_BUSY  input  1  transmitter cannot accept a byte; rises no later than 1 cycle after TX_WRITE

Behaviour:
- Reset (RESET_n low at a CLK edge): ACK_n=1, BUSY=0, TX_WRITE=0, TX_DATA=8'h00, internal index=0, state=IDLE. Reset mid-transfer aborts immediately. No further TX_WRITE is issued.
- States: IDLE, FETCH, ISSUE, HOLD, CRLF_CR, CRLF_LF, COMPLETE.
- IDLE: when REQ_n=0, latch len=min(LENGTH,COUNT) and nl=NEWLINE, set index=0, BUSY=1, go to FETCH.
- FETCH:
  - If index==len: go to CRLF_CR if nl=1, otherwise go to COMPLETE.
  - Otherwise take byte b=DATA[index]. If b==8'h0A and the LF-pending flag is clear, set pending flag and emit CR. Otherwise emit b, clear the flag, and increment index.
  - Emitting means loading TX_DATA and going to ISSUE.
- ISSUE: wait for TX_BUSY=0, then pulse TX_WRITE=1 for exactly one cycle and go to HOLD.
- HOLD: ignore TX_BUSY in the first cycle after the strobe. From then on, wait for TX_BUSY=0, then return to the state that issued the byte's successor (FETCH, CRLF_LF or COMPLETE).
- CRLF_CR emits 8'h0D. CRLF_LF emits 8'h0A. Both use the same ISSUE/HOLD sequence.
- COMPLETE: ACK_n=0. When REQ_n=1: ACK_n=1 and BUSY=0 on the next edge, go to IDLE.
- Exactly one TX_WRITE per emitted byte. The minimum spacing between strobes is 3 cycles even with TX_BUSY tied low.
- Throughput: first TX_WRITE occurs 3 cycles after the REQ_n=0 sample when TX_BUSY=0.
- LENGTH=0, NEWLINE=0: no TX_WRITE; ACK_n low 2 cycles after accept.
- LENGTH>COUNT: clamped to COUNT; no out-of-range DATA access.
- Abort: REQ_n=1 while in FETCH/ISSUE/HOLD/CRLF_*. The byte already strobed completes its HOLD. No further bytes are sent. Go to IDLE with ACK_n kept 1 and BUSY cleared.
- REQ_n low again while in COMPLETE is not a new request. A new request is only accepted in IDLE.
- CR (8'h0D) in DATA is sent verbatim (no expansion). LF expansion yields CR then LF, each counted as separate strobes.

Test Plan:
- Reset: hold RESET_n=0 for 2 cycles with REQ_n=0 -> ACK_n=1, BUSY=0, TX_WRITE never 1. Release -> request accepted on first active edge.
- DATA="OK" (4F,4B), LENGTH=2, NEWLINE=1, TX_BUSY=0 -> TX_WRITE bytes 4F,4B,0D,0A in order, 4 strobes, then ACK_n=0. REQ_n=1 -> ACK_n=1 next cycle.
- DATA=41,0A,42, LENGTH=3, NEWLINE=0 -> bytes 41,0D,0A,42. Then set TX_BUSY=1 for 10 cycles after each strobe -> no strobe while TX_BUSY=1; same byte sequence.
- LENGTH=0, NEWLINE=0 -> zero strobes, ACK_n=0 within 2 cycles. LENGTH=COUNT+5 -> exactly COUNT strobes, DATA[0..COUNT-1].
- LENGTH=8, raise REQ_n after 3rd strobe -> at most 3 strobes total, BUSY=0 afterwards, ACK_n stays 1. A new request then restarts from DATA[0].
- Assert RESET_n=0 mid-transfer during HOLD -> TX_WRITE=0 from the next edge, state IDLE, a subsequent request sends from DATA[0].
